// File: rtl/wb_shared_bus_rr.sv
// Shared-bus Wishbone (pipelined) interconnect, NUM_M masters to NUM_S slaves.
//   - Round-robin arbitration; a grant is held until the granted master drops cyc.
//   - Base/size window decode; the lowest slave index wins on overlap.
//   - At most MAX_OUTSTANDING issued-but-unanswered requests. All of them must
//     target one slave, which keeps responses in order.
//   - A decode miss is accepted when nothing is outstanding, and answered with
//     err on the following cycle.
//   - Bus-timeout abort after TIMEOUT_CYCLES cycles with no response.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   m_cyc/stb/we_i, m_adr/dat_w/sel_i master requests (flattened per master)
//   m_stall/ack/err_o, m_dat_r_o      master responses (read data is shared)
//   s_cyc/stb_o                       per-slave controls (one-hot or zero)
//   s_we/adr/dat_w/sel_o              shared slave request bus
//   s_stall/ack/err_i, s_dat_r_i      slave responses (flattened per slave)
module wb_shared_bus_rr #(
  parameter int unsigned               NUM_M           = 3,
  parameter int unsigned               NUM_S           = 12,
  parameter logic [NUM_S*32-1:0]       BASE_ADDR       = '0,
  parameter logic [NUM_S*32-1:0]       SIZE            = {NUM_S{32'h10}},
  parameter int unsigned               MAX_OUTSTANDING = 4,
  parameter int unsigned               TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*32-1:0] m_adr_i,
  input  logic [NUM_M*32-1:0] m_dat_w_i,
  input  logic [NUM_M*4-1:0]  m_sel_i,
  output logic [NUM_M-1:0]    m_stall_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [NUM_M*32-1:0] m_dat_r_o,
  output logic [NUM_S-1:0]    s_cyc_o,
  output logic [NUM_S-1:0]    s_stb_o,
  output logic                s_we_o,
  output logic [31:0]         s_adr_o,
  output logic [31:0]         s_dat_w_o,
  output logic [3:0]          s_sel_o,
  input  logic [NUM_S-1:0]    s_stall_i,
  input  logic [NUM_S-1:0]    s_ack_i,
  input  logic [NUM_S-1:0]    s_err_i,
  input  logic [NUM_S*32-1:0] s_dat_r_i
);

  localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [3:0]    outst_q, outst_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] pend_q, pend_d;   // slave holding the outstanding requests
  logic          derr_q, derr_d;   // decode miss accepted last cycle
  logic          tblk_q, tblk_d;   // second cycle of the timeout blanking

  // Granted master's request
  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;

  // Decode and the response mux
  logic          hit_any, d_stall;
  logic [SW-1:0] dec_idx;
  logic          p_ack, p_err;
  logic [31:0]   p_dat;

  logic in_grant, busy, resp_ack, resp_err, resp, tout, blocked;
  logic force_stall, issue, acc_hit, acc_miss, found;

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (GW'(i) == grant_q) begin
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        g_we  = m_we_i[i];
        g_adr = m_adr_i[i*32 +: 32];
        g_dat = m_dat_w_i[i*32 +: 32];
        g_sel = m_sel_i[i*4 +: 4];
      end
    end
  end

  always_comb begin
    hit_any = 1'b0;
    dec_idx = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (!hit_any &&
          ((g_adr & ~(SIZE[s*32 +: 32] - 32'd1)) == BASE_ADDR[s*32 +: 32])) begin
        hit_any = 1'b1;
        dec_idx = SW'(s);
      end
    end
  end

  always_comb begin
    d_stall = 1'b0;
    p_ack   = 1'b0;
    p_err   = 1'b0;
    p_dat   = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (SW'(s) == dec_idx) d_stall = s_stall_i[s];
      if (SW'(s) == pend_q) begin
        p_ack = s_ack_i[s];
        p_err = s_err_i[s];
        p_dat = s_dat_r_i[s*32 +: 32];
      end
    end
  end

  always_comb begin
    in_grant = (state_q == ST_GRANT) && g_cyc;
    busy     = (outst_q != 4'd0);
    // Only the pending slave may answer, and only while something is outstanding.
    resp_ack = in_grant && busy && p_ack;
    resp_err = in_grant && busy && p_err;
    resp     = resp_ack || resp_err;
    tout     = in_grant && busy && !resp && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    blocked  = tout || tblk_q;
    // A miss waits until the bus drains. A hit waits while an older request is
    // outstanding at a different slave.
    force_stall = blocked || derr_q ||
                  (outst_q == 4'(MAX_OUTSTANDING)) ||
                  (busy && (!hit_any || (dec_idx != pend_q)));
    issue    = in_grant && g_stb && hit_any && !force_stall;
    acc_hit  = issue && !d_stall;
    acc_miss = in_grant && g_stb && !hit_any && !force_stall;
  end

  always_comb begin
    s_cyc_o   = '0;
    s_stb_o   = '0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_w_o = '0;
    s_sel_o   = '0;
    m_stall_o = '1;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_dat_r_o = {NUM_M{p_dat}};
    if (state_q == ST_GRANT) begin
      s_we_o    = g_we;
      s_adr_o   = g_adr;
      s_dat_w_o = g_dat;
      s_sel_o   = g_sel;
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (GW'(i) == grant_q) begin
          m_stall_o[i] = force_stall || (hit_any && d_stall);
          m_ack_o[i]   = resp_ack;
          m_err_o[i]   = resp_err || tout || (in_grant && derr_q);
        end
      end
      if (in_grant && !blocked) begin
        for (int unsigned s = 0; s < NUM_S; s++) begin
          if (busy) s_cyc_o[s] = (SW'(s) == pend_q);
          else      s_cyc_o[s] = g_stb && hit_any && (SW'(s) == dec_idx);
          s_stb_o[s] = issue && (SW'(s) == dec_idx);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    derr_d  = 1'b0;
    tblk_d  = 1'b0;
    found   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        outst_d = '0;
        timer_d = '0;
        // First requester after last_grant, wrapping around.
        for (int unsigned k = 1; k <= NUM_M; k++) begin
          for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!found && (i == (32'(last_q) + k) % NUM_M) && m_cyc_i[i]) begin
              found   = 1'b1;
              grant_d = GW'(i);
            end
          end
        end
        if (found) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
          outst_d = '0;
          timer_d = '0;
        end else if (tout) begin
          outst_d = '0;
          timer_d = '0;
          tblk_d  = 1'b1;
        end else begin
          outst_d = outst_q + {3'b000, acc_hit} - {3'b000, resp};
          if (acc_hit) pend_d = dec_idx;
          derr_d = acc_miss;
          if (resp || !busy) timer_d = '0;
          else               timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_M - 1);
      outst_q <= '0;
      timer_q <= '0;
      pend_q  <= '0;
      derr_q  <= 1'b0;
      tblk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      derr_q  <= derr_d;
      tblk_q  <= tblk_d;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus_rr.sv
// Testbench for wb_shared_bus_rr: 3 masters, 2 slaves
// (slave0 0x0/0x10000, slave1 0x10000000/0x10), MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16.
module tb_wb_shared_bus_rr;
  localparam int unsigned NM = 3;
  localparam int unsigned NS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*32-1:0] m_adr, m_dat_w;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_stall, m_ack, m_err;
  logic [NM*32-1:0] m_dat_r;
  logic [NS-1:0]    s_cyc, s_stb;
  logic             s_we;
  logic [31:0]      s_adr, s_dat_w;
  logic [3:0]       s_sel;
  logic [NS-1:0]    s_stall, s_ack, s_err;
  logic [NS*32-1:0] s_dat_r;

  int errors = 0;
  int checks = 0;

  wb_shared_bus_rr #(
    .NUM_M(3),
    .NUM_S(2),
    .BASE_ADDR({32'h1000_0000, 32'h0000_0000}),
    .SIZE({32'h0000_0010, 32'h0001_0000}),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_w_i(m_dat_w), .m_sel_i(m_sel),
    .m_stall_o(m_stall), .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_r_o(m_dat_r),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_w_o(s_dat_w), .s_sel_o(s_sel),
    .s_stall_i(s_stall), .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_r_i(s_dat_r)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [1:0]  exp_stb;
    logic [31:0] rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int unsigned i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*32 +: 32]   = adr;
    m_dat_w[i*32 +: 32] = dat;
    m_sel[i*4 +: 4]     = sel;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_stall = '0; s_ack = '0; s_err = '0; s_dat_r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_stall", m_stall, 3'b111);
    chk("rst_m_ack", m_ack, 3'b000);
    chk("rst_m_err", m_err, 3'b000);
    chk("rst_s_cyc", s_cyc, 2'b00);
    chk("rst_s_stb", s_stb, 2'b00);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_s_dat_w", s_dat_w, 32'h0);
    chk("rst_s_we_sel", {s_we, s_sel}, 5'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1);
  end

  logic [2:0]  exp_st;
  logic [2:0]  exp_oh;
  logic        ack_c, stall_c;
  int unsigned g;
  int unsigned order[4];

  initial begin
    //            adr            we    dat            sel     stb    rdata          err
    vecs[0] = '{32'h0000_0000, 1'b0, 32'h0,         4'hF, 2'b01, 32'h1111_2222, 1'b0};
    vecs[1] = '{32'h0000_FFFC, 1'b1, 32'hDEAD_BEEF, 4'hC, 2'b01, 32'h0,         1'b0};
    vecs[2] = '{32'h1000_0000, 1'b0, 32'h0,         4'hF, 2'b10, 32'h3333_4444, 1'b0};
    vecs[3] = '{32'h1000_000C, 1'b0, 32'h0,         4'h3, 2'b10, 32'h5555_6666, 1'b0};
    vecs[4] = '{32'h1000_0010, 1'b0, 32'h0,         4'hF, 2'b00, 32'h0,         1'b1};
    vecs[5] = '{32'h0001_0000, 1'b0, 32'h0,         4'hF, 2'b00, 32'h0,         1'b1};
    vecs[6] = '{32'h2000_0000, 1'b1, 32'hCAFE_0001, 4'hF, 2'b00, 32'h0,         1'b1};
    vecs[7] = '{32'h0000_ABCD, 1'b0, 32'h0,         4'h1, 2'b01, 32'h7777_8888, 1'b0};
    order = '{0, 1, 2, 0};

    // Single read from M1 to slave1
    do_reset();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'hF);
    #1;
    chk("t1_idle_stall", m_stall, 3'b111);
    chk("t1_idle_scyc", s_cyc, 2'b00);
    tick();
    chk("t1_grant_stall", m_stall, 3'b101);
    chk("t1_s_cyc", s_cyc, 2'b10);
    chk("t1_s_stb", s_stb, 2'b10);
    chk("t1_s_adr", s_adr, 32'h1000_0004);
    tick();
    m_stb[1] = 1'b0;
    s_ack[1] = 1'b1;
    s_dat_r[63:32] = 32'hA5A5_A5A5;
    #1;
    chk("t1_m_ack", m_ack, 3'b010);
    chk("t1_m_dat_r", m_dat_r[63:32], 32'hA5A5_A5A5);
    chk("t1_s_cyc_hold", s_cyc, 2'b10);
    tick();
    s_ack = '0;
    m_cyc[1] = 1'b0;
    tick();

    // Round robin with all masters requesting
    do_reset();
    for (int unsigned i = 0; i < NM; i++)
      set_m(i, 1'b1, 1'b1, 1'b0, 32'h100 * (i + 1), 32'h0, 4'hF);
    #1;
    chk("t2_idle_stall", m_stall, 3'b111);
    tick();
    for (int unsigned r = 0; r < 4; r++) begin
      g = order[r];
      exp_st = 3'b111; exp_st[g] = 1'b0;
      exp_oh = 3'b000; exp_oh[g] = 1'b1;
      chk("t2_grant_stall", m_stall, exp_st);
      chk("t2_s_adr", s_adr, 32'h100 * (g + 1));
      chk("t2_s_stb", s_stb, 2'b01);
      tick();
      m_stb[g] = 1'b0;
      s_ack[0] = 1'b1;
      #1;
      chk("t2_ack", m_ack, exp_oh);
      tick();
      s_ack[0] = 1'b0;
      m_cyc[g] = 1'b0;
      #1;
      chk("t2_drop_scyc", s_cyc, 2'b00);
      tick();
      m_cyc[g] = 1'b1;
      m_stb[g] = 1'b1;
      #1;
      chk("t2_rearb_stall", m_stall, 3'b111);
      tick();
    end
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Decode table with M0 holding the grant
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    for (int unsigned v = 0; v < 8; v++) begin
      set_m(0, 1'b1, 1'b1, vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel);
      #1;
      chk("tv_s_stb", s_stb, vecs[v].exp_stb);
      chk("tv_s_cyc", s_cyc, vecs[v].exp_stb);
      chk("tv_m_stall", m_stall, 3'b110);
      chk("tv_s_adr", s_adr, vecs[v].adr);
      chk("tv_s_dat_w", s_dat_w, vecs[v].dat);
      chk("tv_s_we_sel", {s_we, s_sel}, {vecs[v].we, vecs[v].sel});
      tick();
      m_stb[0] = 1'b0;
      // The non-target slave raises ack and err; both must be ignored.
      s_ack = 2'b11;
      if (vecs[v].exp_stb == 2'b01) begin
        s_err = 2'b10;
        s_dat_r = {32'hBAD0_BAD0, vecs[v].rdata};
      end else if (vecs[v].exp_stb == 2'b10) begin
        s_err = 2'b01;
        s_dat_r = {vecs[v].rdata, 32'hBAD0_BAD0};
      end else begin
        s_err = 2'b00;
        s_dat_r = {32'hBAD0_BAD0, 32'hBAD0_BAD0};
      end
      #1;
      chk("tv_m_ack", m_ack, {2'b00, |vecs[v].exp_stb});
      chk("tv_m_err", m_err, {2'b00, vecs[v].exp_err});
      if (vecs[v].exp_stb != 2'b00) chk("tv_m_dat_r", m_dat_r[31:0], vecs[v].rdata);
      tick();
      s_ack = '0;
      s_err = '0;
    end

    // Outstanding limit: 6 back-to-back reads, slave0 acks 10 cycles after accept
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    for (int unsigned c = 0; c < 24; c++) begin
      m_stb[0] = (c <= 12);
      ack_c = ((c >= 10) && (c <= 13)) || (c == 21) || (c == 22);
      stall_c = (c >= 4) && (c <= 10);
      s_ack[0] = ack_c;
      s_dat_r[31:0] = 32'hC000_0000 + c;
      #1;
      if (c <= 12) begin
        chk("t3_stall", m_stall[0], stall_c);
        chk("t3_s_stb", s_stb, stall_c ? 2'b00 : 2'b01);
      end
      chk("t3_ack", m_ack[0], ack_c);
      if (ack_c) chk("t3_dat", m_dat_r[31:0], 32'hC000_0000 + c);
      tick();
    end
    s_ack = '0;

    // Timeout: write to slave1 which never answers
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h1234_5678, 4'hF);
    #1;
    chk("t5_issue", s_stb, 2'b10);
    chk("t5_stall", m_stall[0], 1'b0);
    tick();
    m_stb[0] = 1'b0;
    for (int unsigned k = 1; k <= 15; k++) begin
      #1;
      chk("t5_wait_err", m_err[0], 1'b0);
      chk("t5_wait_scyc", s_cyc, 2'b10);
      tick();
    end
    #1;
    chk("t5_tout_err", m_err[0], 1'b1);
    chk("t5_tout_scyc", s_cyc, 2'b00);
    chk("t5_tout_sstb", s_stb, 2'b00);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    #1;
    chk("t5_blank_scyc", s_cyc, 2'b00);
    chk("t5_blank_sstb", s_stb, 2'b00);
    chk("t5_blank_stall", m_stall[0], 1'b1);
    chk("t5_blank_err", m_err[0], 1'b0);
    tick();
    chk("t5_retry_sstb", s_stb, 2'b01);
    chk("t5_retry_stall", m_stall[0], 1'b0);
    tick();
    m_stb[0] = 1'b0;
    s_ack[0] = 1'b1;
    s_dat_r[31:0] = 32'h600D_600D;
    #1;
    chk("t5_retry_ack", m_ack, 3'b001);
    chk("t5_retry_dat", m_dat_r[31:0], 32'h600D_600D);
    tick();
    s_ack = '0;

    // M0 drops cyc with two outstanding; late ack; M1 gets the bus next
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'hF);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    #1;
    chk("t6_stall", m_stall, 3'b110);
    chk("t6_s_stb0", s_stb, 2'b01);
    tick();
    chk("t6_s_stb1", s_stb, 2'b01);
    tick();
    m_stb[0] = 1'b0;
    m_cyc[0] = 1'b0;
    s_ack[0] = 1'b1;
    #1;
    chk("t6_drop_scyc", s_cyc, 2'b00);
    chk("t6_drop_ack", m_ack, 3'b000);
    tick();
    chk("t6_idle_ack", m_ack, 3'b000);
    chk("t6_idle_scyc", s_cyc, 2'b00);
    chk("t6_idle_stall", m_stall, 3'b111);
    tick();
    chk("t6_m1_stall", m_stall, 3'b101);
    chk("t6_m1_scyc", s_cyc, 2'b10);
    chk("t6_m1_adr", s_adr, 32'h1000_0004);
    chk("t6_late_ack", m_ack, 3'b000);
    tick();
    m_stb[1] = 1'b0;
    s_ack = 2'b10;
    s_dat_r[63:32] = 32'h7777_8888;
    #1;
    chk("t6_m1_ack", m_ack, 3'b010);
    chk("t6_m1_dat", m_dat_r[63:32], 32'h7777_8888);
    tick();
    s_ack = '0;
    m_cyc = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus_rr.md
Name: wb_shared_bus_rr

Overview:
Parametrised successor to the fixed-priority shared-bus Wishbone interconnect. It connects NUM_M pipelined Wishbone masters to NUM_S slaves over one shared bus, using round-robin arbitration. Address decode uses base/size windows. It adds three behaviours the previous block lacks: an outstanding-transaction limit, decode-error generation and a bus-timeout abort. It sits between the CPU/debug masters and all SoC peripherals.

Parameters:
- NUM_M, 3, number of masters (1..8).
- NUM_S, 12, number of slaves (1..16).
- BASE_ADDR, all zero, NUM_S*32-bit flattened array; slave s window base at bits [s*32+:32].
- SIZE, 32'h10 per slave, NUM_S*32-bit flattened array of byte window sizes; each must be a power of two and base-aligned.
- MAX_OUTSTANDING, 4, maximum issued-but-unacknowledged requests (1..15).
- TIMEOUT_CYCLES, 1024, cycles without ack/err before abort (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- m_cyc, m_stb, m_we  in  NUM_M each  master controls.
- m_adr, m_dat_w  in  NUM_M*32  master address/write data.
- m_sel  in  NUM_M*4  byte selects.
- m_stall, m_ack, m_err  out  NUM_M each  master responses.
- m_dat_r  out  NUM_M*32  read data; the shared bus value is driven to all masters.
- s_cyc, s_stb  out  NUM_S each  slave controls; one-hot or zero.
- s_we  out  1  shared.
- s_adr, s_dat_w  out  32  shared.
- s_sel  out  4  shared.
- s_stall, s_ack, s_err  in  NUM_S each  slave responses.
- s_dat_r  in  NUM_S*32  slave read data.

Behaviour:
- Reset: state IDLE, grant none, last_grant=NUM_M-1, outstanding=0, timer=0. All m_stall=1, m_ack=m_err=0, s_cyc=s_stb=0, s_adr/s_dat_w/s_sel/s_we=0.
- FSM IDLE:
  - If any m_cyc, grant the first requester searching from last_grant+1 with wrap.
  - Go to GRANT next cycle, so arbitration latency is 1 cycle.
  - m_stall=1 for all masters in IDLE.
- FSM GRANT:
  - The granted master's adr/dat/sel/we route to the shared slave bus.
  - Non-granted masters see stall=1 and ack=err=0.
  - If the granted master's m_cyc falls: go to IDLE, update last_grant, clear outstanding and timer, and drop s_cyc in the same cycle. Late acks are discarded.
- Decode: slave s hits when (adr & ~(SIZE_s-1)) == BASE_s. The lowest index wins on overlap.
- Request issue (stb with hit):
  - s_cyc[s] is held while outstanding>0 or a stb is present.
  - s_stb[s]=m_stb.
  - m_stall is the selected slave's s_stall.
  - An accepted request (stb & ~stall) increments outstanding.
- Forced stall: m_stall=1 and s_stb=0 when either condition holds:
  - outstanding==MAX_OUTSTANDING;
  - outstanding>0 and the decoded slave differs from the slave holding the pending transactions.
  - This preserves response order.
- Decode miss:
  - Accepted with m_stall=0 only when outstanding==0; otherwise stall.
  - No slave is strobed.
  - m_err=1 exactly one cycle later.
- Responses:
  - m_ack/m_err of the granted master = the pending slave's s_ack/s_err, combinational.
  - m_dat_r = the pending slave's s_dat_r.
  - Each ack/err decrements outstanding.
  - Accept and response in the same cycle leave outstanding unchanged.
- Timeout:
  - timer increments while outstanding>0 and no ack/err occurs; it resets on any ack/err or when outstanding==0.
  - At timer==TIMEOUT_CYCLES-1: m_err=1 for one cycle, outstanding=0, s_cyc/s_stb forced to 0 that cycle and the next.
  - Grant is retained while m_cyc stays high.
- Responses from non-selected slaves are ignored.

Test Plan:
Bench configuration: NUM_M=3, NUM_S=2; slave0 base 0x0 size 0x10000; slave1 base 0x10000000 size 0x10; TIMEOUT_CYCLES=16; MAX_OUTSTANDING=4.
1. Reset, then M1 cyc/stb read at 0x10000004 with slave1 acking data 0xA5A5A5A5 next cycle -> grant after 1 cycle; s_cyc=2'b10; M1 gets ack with 0xA5A5A5A5; M0/M2 stall=1.
2. All three masters hold cyc continuously, one transaction each then cyc drop -> grant order M0, M1, M2, M0 (round robin, no starvation).
3. M0 issues 6 back-to-back stbs to slave0, which never stalls and acks with a 10-cycle delay -> exactly 4 accepted, then m_stall=1 until the first ack; outstanding never exceeds 4.
4. M0 stb at 0x20000000 -> no s_stb; m_err=1 exactly one cycle later.
5. M0 write to slave1, slave never acks -> m_err on cycle 16 after issue; s_cyc low for 2 cycles; a subsequent request succeeds.
6. M0 drops cyc with 2 outstanding; late ack arrives -> no m_ack; s_cyc=0; M1 is granted next.
